weight_mem_ctrl: RTL and testbench
==================================

// Module: weight_mem_ctrl
// PURPOSE
//  Sequencer for the weight memory path (256->324 width converter + 9-DRM weight buffer).
//  Clears the converter, issues DRM write addresses as converted beats arrive, and issues
//  DRM read addresses plus an aligned valid for the MAC array.
//  Pulses state_rst to the top FSM when a load or read pass completes.
//  Sits beside the weight memory top-level and drives its addr_wr/addr_rd/cvt_rstn ports.
// PARAMETERS
//  WR_ADDR_DEPTH  10    DRM write address width
//  RD_ADDR_DEPTH  8     DRM read address width
//  WR_LEN         1024  324-bit beats per weight load (must be <= 2**WR_ADDR_DEPTH)
//  RD_LEN         256   1296-bit words per read pass (must be <= 2**RD_ADDR_DEPTH)
//  RD_LATENCY     2     DRM read latency in cycles, >=1; valid_out delay
// PORTS
//  sys_clk        in   1              single clock; write and read sides both run on it
//  rst            in   1              asynchronous, active-high reset
//  current_state  in   3              top FSM state: 0 IDLE, 1 LOAD_WEIGHT, 2 CALC, others = IDLE
//  wr_beat_valid  in   1              converter output valid (one 324-bit beat into DRM)
//  rd_en          in   1              MAC ready; read address advances only when high
//  cvt_rstn       out  1              active-low synchronous clear to width converter
//  addr_wr        out  WR_ADDR_DEPTH  DRM write address
//  addr_rd        out  RD_ADDR_DEPTH  DRM read address
//  valid_out      out  1              DRM read data valid, aligned to DRM output
//  state_rst      out  1              1-cycle done pulse to top FSM
//  busy           out  1              high in any state other than S_IDLE
// BEHAVIOUR
//  Reset values: cvt_rstn=0, addr_wr=0, addr_rd=0, valid_out=0, state_rst=0, busy=0;
//   internal FSM = S_IDLE, valid shift register cleared.
//  FSM states: S_IDLE, S_CLR, S_LOAD, S_LDONE, S_READ, S_RDONE.
//  S_IDLE:
//   - cvt_rstn=1; addr_wr=0, addr_rd=0.
//   - current_state==1 -> S_CLR; current_state==2 -> S_READ.
//  S_CLR (exactly 1 cycle): cvt_rstn=0, then -> S_LOAD.
//  S_LOAD:
//   - cvt_rstn=1.
//   - Each cycle with wr_beat_valid=1: addr_wr presented this cycle is the write address;
//     addr_wr increments on the next edge.
//   - Beat counter reaching WR_LEN (last beat at addr WR_LEN-1) -> S_LDONE.
//   - wr_beat_valid outside S_LOAD is ignored; no address change.
//  S_LDONE (1 cycle): state_rst=1, addr_wr cleared to 0, then -> S_IDLE.
//  S_READ:
//   - Each cycle with rd_en=1: issue read at addr_rd; addr_rd increments next edge.
//   - After issuing RD_LEN-1 -> S_RDONE.
//   - rd_en=0 holds addr_rd (stall); no read issued.
//  Read valid: read-issue strobe enters a RD_LATENCY-deep shift register;
//   valid_out = its last stage. Pipeline keeps draining in S_RDONE/S_IDLE.
//  S_RDONE: waits until the valid pipeline is empty, then state_rst=1 for 1 cycle,
//   addr_rd cleared to 0, -> S_IDLE.
//  Abort: in S_CLR/S_LOAD, current_state!=1; or in S_READ, current_state!=2
//   -> next edge S_IDLE; addr_wr/addr_rd cleared, valid pipeline flushed,
//      no state_rst pulse, cvt_rstn pulsed 0 for that one cycle.
//  state_rst is only raised in S_LDONE or S_RDONE; never two consecutive cycles.
//  Counters wrap only if LEN == 2**DEPTH; the FSM leaves before wrap is used.
//  rst asserted mid-operation: all outputs return to reset values immediately (async).
// TESTING
//  1. Load, WR_LEN=1024, wr_beat_valid continuous: cvt_rstn low 1 cycle; addr_wr 0..1023;
//     state_rst 1 cycle after beat 1023; addr_wr back to 0.
//  2. Load, wr_beat_valid 1-in-3: addr_wr advances only on valid beats; done after 1024 beats.
//  3. Read, RD_LEN=256, rd_en=1, RD_LATENCY=2: addr_rd 0..255; valid_out high 256 cycles
//     starting 2 cycles after first issue; state_rst after last valid.
//  4. Read stall: rd_en low 5 cycles at addr_rd=100: addr_rd holds at 100;
//     valid_out shows a 5-cycle gap; 256 total valids.
//  5. Abort: current_state 1->0 at addr_wr=500: next cycle S_IDLE, addr_wr=0,
//     cvt_rstn=0 for 1 cycle, no state_rst.
//  6. Async rst at addr_rd=37 mid-read: outputs zero without a clock edge; after release,
//     current_state=2 restarts from addr_rd=0.

Source files
------------

// File: rtl/weight_mem_ctrl_if.sv
// Control/address bundle between the weight memory sequencer and the weight memory top-level.
// master = sequencer side, slave = top FSM / memory side.
interface weight_mem_ctrl_if #(
    parameter int unsigned WR_ADDR_DEPTH = 10,
    parameter int unsigned RD_ADDR_DEPTH = 8
);
    logic [2:0]               current_state;
    logic                     wr_beat_valid;
    logic                     rd_en;
    logic                     cvt_rstn;
    logic [WR_ADDR_DEPTH-1:0] addr_wr;
    logic [RD_ADDR_DEPTH-1:0] addr_rd;
    logic                     valid_out;
    logic                     state_rst;
    logic                     busy;

    modport master (
        input  current_state, wr_beat_valid, rd_en,
        output cvt_rstn, addr_wr, addr_rd, valid_out, state_rst, busy
    );

    modport slave (
        output current_state, wr_beat_valid, rd_en,
        input  cvt_rstn, addr_wr, addr_rd, valid_out, state_rst, busy
    );
endinterface

// File: rtl/weight_mem_ctrl.sv
// Sequencer for the weight memory path: clears the width converter, walks DRM write/read
// addresses, aligns read valid to DRM latency and pulses state_rst when a pass completes.
module weight_mem_ctrl #(
    parameter int unsigned WR_ADDR_DEPTH = 10,
    parameter int unsigned RD_ADDR_DEPTH = 8,
    parameter int unsigned WR_LEN        = 1024,
    parameter int unsigned RD_LEN        = 256,
    parameter int unsigned RD_LATENCY    = 2
) (
    input  logic               sys_clk,
    input  logic               rst,
    weight_mem_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_LDONE,
        S_READ,
        S_RDONE
    } state_t;

    state_t                   state;
    logic [WR_ADDR_DEPTH-1:0] addr_wr_q;
    logic [RD_ADDR_DEPTH-1:0] addr_rd_q;
    logic                     cvt_rstn_q;
    logic                     state_rst_q;
    logic                     busy_q;
    logic [RD_LATENCY-1:0]    vld_sr;

    logic                     load_req;
    logic                     read_req;
    logic                     issue;
    logic                     wr_last;
    logic                     rd_last;
    logic [RD_LATENCY-1:0]    vld_shift;

    assign load_req  = (bus.current_state == 3'd1);
    assign read_req  = (bus.current_state == 3'd2);
    assign issue     = (state == S_READ) && read_req && bus.rd_en;
    assign wr_last   = (addr_wr_q == WR_ADDR_DEPTH'(WR_LEN - 1));
    assign rd_last   = (addr_rd_q == RD_ADDR_DEPTH'(RD_LEN - 1));
    // Pipeline contents after the next edge when nothing new is issued.
    assign vld_shift = vld_sr << 1;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_wr_q   <= '0;
            addr_rd_q   <= '0;
            cvt_rstn_q  <= 1'b0;
            state_rst_q <= 1'b0;
            busy_q      <= 1'b0;
            vld_sr      <= '0;
        end else begin
            vld_sr      <= vld_shift | RD_LATENCY'(issue);
            state_rst_q <= 1'b0;
            cvt_rstn_q  <= 1'b1;
            case (state)
                S_IDLE: begin
                    addr_wr_q <= '0;
                    addr_rd_q <= '0;
                    if (load_req) begin
                        state      <= S_CLR;
                        cvt_rstn_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else if (read_req) begin
                        state  <= S_READ;
                        busy_q <= 1'b1;
                    end
                end
                S_CLR: begin
                    if (!load_req) begin
                        state      <= S_IDLE;
                        busy_q     <= 1'b0;
                        cvt_rstn_q <= 1'b0;
                        addr_wr_q  <= '0;
                        addr_rd_q  <= '0;
                        vld_sr     <= '0;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!load_req) begin
                        state      <= S_IDLE;
                        busy_q     <= 1'b0;
                        cvt_rstn_q <= 1'b0;
                        addr_wr_q  <= '0;
                        addr_rd_q  <= '0;
                        vld_sr     <= '0;
                    end else if (bus.wr_beat_valid) begin
                        if (wr_last) begin
                            state       <= S_LDONE;
                            state_rst_q <= 1'b1;
                            addr_wr_q   <= '0;
                        end else begin
                            addr_wr_q <= addr_wr_q + 1'b1;
                        end
                    end
                end
                S_LDONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                S_READ: begin
                    if (!read_req) begin
                        state      <= S_IDLE;
                        busy_q     <= 1'b0;
                        cvt_rstn_q <= 1'b0;
                        addr_wr_q  <= '0;
                        addr_rd_q  <= '0;
                        vld_sr     <= '0;
                    end else if (bus.rd_en) begin
                        if (rd_last) begin
                            state     <= S_RDONE;
                            addr_rd_q <= '0;
                        end else begin
                            addr_rd_q <= addr_rd_q + 1'b1;
                        end
                    end
                end
                S_RDONE: begin
                    // Done pulse lands on the first cycle the valid pipeline is empty.
                    if (state_rst_q) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else if (vld_shift == '0) begin
                        state_rst_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cvt_rstn  = cvt_rstn_q;
    assign bus.addr_wr   = addr_wr_q;
    assign bus.addr_rd   = addr_rd_q;
    assign bus.valid_out = vld_sr[RD_LATENCY-1];
    assign bus.state_rst = state_rst_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Scoreboard bench for weight_mem_ctrl: load, paced load, read, stalled read, abort, async reset.
module tb_weight_mem_ctrl;

    localparam int unsigned WD = 10;
    localparam int unsigned RD = 8;
    localparam int unsigned WL = 1024;
    localparam int unsigned RL_LEN = 256;
    localparam int unsigned RL = 2;

    typedef struct {
        int due;
        int addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_mem_ctrl_if #(.WR_ADDR_DEPTH(WD), .RD_ADDR_DEPTH(RD)) bus ();

    weight_mem_ctrl #(
        .WR_ADDR_DEPTH(WD), .RD_ADDR_DEPTH(RD),
        .WR_LEN(WL), .RD_LEN(RL_LEN), .RD_LATENCY(RL)
    ) dut (
        .sys_clk(clk),
        .rst    (rst),
        .bus    (bus)
    );

    // DRM stand-in: returns the address it was read at, RL cycles later.
    logic [RD-1:0] drm [RL];
    always @(posedge clk) begin
        drm[0] <= bus.addr_rd;
        for (int i = 1; i < RL; i++) drm[i] <= drm[i-1];
    end

    exp_t sb_q[$];
    int   cyc    = 0;
    int   vcnt   = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_rd_out();
        bit due;
        due = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        check("valid_out", 32'(bus.valid_out), 32'(due));
        if (due) begin
            check("rd_data", 32'(drm[RL-1]), 32'(sb_q[0].addr));
            void'(sb_q.pop_front());
            vcnt++;
        end
    endtask

    task automatic step();
        check_rd_out();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_load(input int gap, input int abort_at);
        bus.current_state = 3'd1;
        bus.wr_beat_valid = 1'b0;
        step();
        check("clr_cvt_rstn", 32'(bus.cvt_rstn), 0);
        check("clr_busy", 32'(bus.busy), 1);
        step();
        check("load_cvt_rstn", 32'(bus.cvt_rstn), 1);
        for (int i = 0; i < int'(WL); i++) begin
            for (int g = 0; g < gap; g++) begin
                check("addr_wr_hold", 32'(bus.addr_wr), 32'(i));
                bus.wr_beat_valid = 1'b0;
                step();
            end
            if (i == abort_at) begin
                check("abort_addr_wr", 32'(bus.addr_wr), 32'(i));
                bus.current_state = 3'd0;
                bus.wr_beat_valid = 1'b1;
                step();
                check("abort_addr_wr0", 32'(bus.addr_wr), 0);
                check("abort_cvt_rstn", 32'(bus.cvt_rstn), 0);
                check("abort_state_rst", 32'(bus.state_rst), 0);
                check("abort_busy", 32'(bus.busy), 0);
                step();
                check("abort_idle_addr", 32'(bus.addr_wr), 0);
                check("abort_idle_cvt", 32'(bus.cvt_rstn), 1);
                check("abort_idle_srst", 32'(bus.state_rst), 0);
                bus.wr_beat_valid = 1'b0;
                return;
            end
            check("addr_wr", 32'(bus.addr_wr), 32'(i));
            check("load_state_rst", 32'(bus.state_rst), 0);
            bus.wr_beat_valid = 1'b1;
            step();
        end
        bus.wr_beat_valid = 1'b0;
        check("ldone_state_rst", 32'(bus.state_rst), 1);
        check("ldone_addr_wr", 32'(bus.addr_wr), 0);
        bus.current_state = 3'd0;
        step();
        check("ldone_pulse_end", 32'(bus.state_rst), 0);
        check("ldone_busy", 32'(bus.busy), 0);
        check("ldone_cvt_rstn", 32'(bus.cvt_rstn), 1);
    endtask

    task automatic do_read(input int stall_at, input int stall_len);
        int exp_a   = 0;
        int stalled = 0;
        int last_due = 0;
        int vstart;
        vstart = vcnt;
        bus.current_state = 3'd2;
        bus.rd_en = 1'b0;
        step();
        check("read_busy", 32'(bus.busy), 1);
        while (exp_a < int'(RL_LEN)) begin
            check("addr_rd", 32'(bus.addr_rd), 32'(exp_a));
            if (exp_a == stall_at && stalled < stall_len) begin
                bus.rd_en = 1'b0;
                stalled++;
            end else begin
                bus.rd_en = 1'b1;
                sb_q.push_back('{cyc + RL, exp_a});
                last_due = cyc + RL;
                exp_a++;
            end
            step();
        end
        bus.rd_en = 1'b0;
        bus.current_state = 3'd0;
        check("rdone_addr_rd", 32'(bus.addr_rd), 0);
        while (cyc <= last_due + 2) begin
            check("rd_state_rst", 32'(bus.state_rst), 32'(cyc == last_due + 1));
            step();
        end
        check("rd_busy_end", 32'(bus.busy), 0);
        check("valid_count", 32'(vcnt - vstart), RL_LEN);
        check("sb_empty", 32'(sb_q.size()), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.current_state = 3'd0;
        bus.wr_beat_valid = 1'b0;
        bus.rd_en = 1'b0;
        #1;
        check("rst_cvt_rstn", 32'(bus.cvt_rstn), 0);
        check("rst_addr_wr", 32'(bus.addr_wr), 0);
        check("rst_addr_rd", 32'(bus.addr_rd), 0);
        check("rst_valid", 32'(bus.valid_out), 0);
        check("rst_state_rst", 32'(bus.state_rst), 0);
        check("rst_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("idle_cvt_rstn", 32'(bus.cvt_rstn), 1);

        // Undefined top states behave as idle.
        bus.current_state = 3'd3;
        step();
        step();
        check("idle_other_busy", 32'(bus.busy), 0);
        check("idle_other_cvt", 32'(bus.cvt_rstn), 1);
        bus.current_state = 3'd0;

        do_load(0, -1);
        do_load(2, -1);
        do_read(-1, 0);
        do_read(100, 5);
        do_load(0, 500);

        // Async reset in the middle of a read pass.
        bus.current_state = 3'd2;
        step();
        bus.rd_en = 1'b1;
        for (int i = 0; i < 37; i++) begin
            check("pre_rst_addr_rd", 32'(bus.addr_rd), 32'(i));
            sb_q.push_back('{cyc + RL, i});
            step();
        end
        check("pre_rst_addr37", 32'(bus.addr_rd), 37);
        #2;
        rst = 1'b1;
        #1;
        check("arst_addr_rd", 32'(bus.addr_rd), 0);
        check("arst_valid", 32'(bus.valid_out), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_cvt_rstn", 32'(bus.cvt_rstn), 0);
        check("arst_state_rst", 32'(bus.state_rst), 0);
        sb_q.delete();
        bus.rd_en = 1'b0;
        bus.current_state = 3'd0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        step();
        check("post_rst_cvt", 32'(bus.cvt_rstn), 1);
        do_read(-1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
